vdma_burst_engine: RTL and testbench

//  Runtime-configurable, multi-channel DMA engine for the vector conv datapath. Per output

---
 rtl/vdma_burst_engine.sv | 222 ++++++++++++++++++++++
 tb/tb_vdma_burst_engine.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdma_burst_engine.sv
// Per-channel burst loader (input plane, KxK weights, BN words) followed by a FIFO-buffered
// activation drain; one read burst in flight, requests held until grant/ack, abort wins always.
module vdma_burst_engine #(
   parameter int DATA_WIDTH     = 16,
   parameter int ADDR_WIDTH     = 32,
   parameter int BURST_LEN      = 8,
   parameter int OUT_FIFO_DEPTH = 4,
   parameter int BN_PARAMS      = 4,
   localparam int LW            = $clog2(BURST_LEN + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [15:0]           cfg_img_w,
   input  logic [15:0]           cfg_img_h,
   input  logic [3:0]            cfg_kernel,
   input  logic [15:0]           cfg_channels,
   input  logic [ADDR_WIDTH-1:0] input_addr,
   input  logic [ADDR_WIDTH-1:0] weight_addr,
   input  logic [ADDR_WIDTH-1:0] bn_param_addr,
   input  logic [ADDR_WIDTH-1:0] output_addr,
   output logic                  rd_req,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [LW-1:0]         rd_len,
   input  logic                  rd_gnt,
   input  logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  rd_valid,
   output logic                  wr_req,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_ack,
   input  logic [DATA_WIDTH-1:0] act_data,
   input  logic                  act_valid,
   output logic                  act_ready,
   input  logic                  processing_done,
   output logic [1:0]            load_phase,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);
   localparam int FAW = (OUT_FIFO_DEPTH > 1) ? $clog2(OUT_FIFO_DEPTH) : 1;
   localparam logic [ADDR_WIDTH-1:0] BYTES_A = ADDR_WIDTH'(DATA_WIDTH / 8);

   typedef enum logic [2:0] {S_IDLE, S_LOAD_IN, S_LOAD_W, S_LOAD_BN, S_WAIT_PROC, S_STORE} state_t;

   state_t                r_state;
   logic [31:0]           r_plane, r_kk, r_total, r_issued, r_accepted, r_written;
   logic [15:0]           r_nch, r_chan;
   logic [ADDR_WIDTH-1:0] r_in_addr, r_wt_addr, r_bn_addr, r_out_addr, r_base, r_out_base;
   logic [ADDR_WIDTH-1:0] r_rd_addr;
   logic [LW-1:0]         r_rd_len, r_beats;
   logic                  r_rd_req, r_open, r_done, r_error;
   logic [DATA_WIDTH-1:0] r_fifo [OUT_FIFO_DEPTH];
   logic [FAW-1:0]        r_wptr, r_rptr;
   logic [FAW:0]          r_count;

   logic [31:0]           w_remaining, w_cfg_plane, w_cfg_kk;
   logic [LW-1:0]         w_len;
   logic                  w_load, w_out_phase, w_full, w_empty, w_push, w_pop, w_phase_end, w_cfg_bad;
   logic [15:0]           w_next_chan;
   logic                  w_unused_rd;

   // Byte offset of a channel's slice within a region: idx * words * BYTES, wrapping.
   function automatic logic [ADDR_WIDTH-1:0] f_off(input logic [31:0] idx, input logic [31:0] words);
      return ADDR_WIDTH'(idx) * ADDR_WIDTH'(words) * BYTES_A;
   endfunction

   assign w_unused_rd  = ^rd_data;
   assign w_cfg_plane  = {16'd0, cfg_img_w} * {16'd0, cfg_img_h};
   assign w_cfg_kk     = {28'd0, cfg_kernel} * {28'd0, cfg_kernel};
   assign w_cfg_bad    = (cfg_img_w == 16'd0) | (cfg_img_h == 16'd0) |
                         (cfg_kernel == 4'd0) | (cfg_channels == 16'd0);
   assign w_remaining  = r_total - r_issued;
   assign w_len        = (w_remaining > 32'(BURST_LEN)) ? LW'(BURST_LEN) : LW'(w_remaining);
   assign w_load       = (r_state == S_LOAD_IN) | (r_state == S_LOAD_W) | (r_state == S_LOAD_BN);
   assign w_out_phase  = (r_state == S_WAIT_PROC) | (r_state == S_STORE);
   assign w_full       = (r_count == (FAW+1)'(OUT_FIFO_DEPTH));
   assign w_empty      = (r_count == '0);
   assign act_ready    = w_out_phase & ~w_full & (r_accepted < r_plane);
   assign w_push       = act_valid & act_ready;
   assign wr_req       = w_out_phase & ~w_empty;
   assign w_pop        = wr_req & wr_ack;
   assign wr_data      = r_fifo[r_rptr];
   assign wr_addr      = r_out_base + ADDR_WIDTH'(r_written) * BYTES_A;
   // Issued already counts the open burst, so its final beat ends the phase.
   assign w_phase_end  = r_open & rd_valid & (r_beats == LW'(1)) & (r_issued == r_total);
   assign w_next_chan  = r_chan + 16'd1;
   assign rd_req       = r_rd_req;
   assign rd_addr      = r_rd_addr;
   assign rd_len       = r_rd_len;
   assign busy         = (r_state != S_IDLE);
   assign done         = r_done;
   assign error        = r_error;

   always_comb begin
      load_phase = 2'd3;
      case (r_state)
         S_LOAD_IN: load_phase = 2'd0;
         S_LOAD_W:  load_phase = 2'd1;
         S_LOAD_BN: load_phase = 2'd2;
         default:   load_phase = 2'd3;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push) r_fifo[r_wptr] <= act_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (abort) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + FAW'(1);
         if (w_pop)  r_rptr <= r_rptr + FAW'(1);
         r_count <= r_count + (FAW+1)'(w_push) - (FAW+1)'(w_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_plane    <= '0;  r_kk      <= '0;  r_total   <= '0;  r_issued  <= '0;
         r_accepted <= '0;  r_written <= '0;  r_nch     <= '0;  r_chan    <= '0;
         r_in_addr  <= '0;  r_wt_addr <= '0;  r_bn_addr <= '0;  r_out_addr <= '0;
         r_base     <= '0;  r_out_base <= '0; r_rd_addr <= '0;  r_rd_len  <= '0;
         r_beats    <= '0;  r_rd_req  <= 1'b0; r_open   <= 1'b0;
         r_done     <= 1'b0; r_error  <= 1'b0;
      end else begin
         r_done  <= 1'b0;
         r_error <= 1'b0;
         if (abort) begin
            r_state    <= S_IDLE;
            r_rd_req   <= 1'b0;
            r_open     <= 1'b0;
            r_beats    <= '0;
            r_issued   <= '0;
            r_total    <= '0;
            r_chan     <= '0;
            r_accepted <= '0;
            r_written  <= '0;
         end else begin
            if (w_push) r_accepted <= r_accepted + 32'd1;
            if (w_pop)  r_written  <= r_written + 32'd1;
            if (w_load) begin
               if (r_rd_req && rd_gnt) begin
                  r_rd_req <= 1'b0;
                  r_open   <= 1'b1;
                  r_beats  <= r_rd_len;
                  r_issued <= r_issued + 32'(r_rd_len);
               end else if (!r_rd_req && !r_open && w_remaining != 32'd0) begin
                  r_rd_req  <= 1'b1;
                  r_rd_addr <= r_base + ADDR_WIDTH'(r_issued) * BYTES_A;
                  r_rd_len  <= w_len;
               end
               if (r_open && rd_valid) begin
                  r_beats <= r_beats - LW'(1);
                  if (r_beats == LW'(1)) r_open <= 1'b0;
               end
            end
            case (r_state)
               S_IDLE: if (start) begin
                  if (w_cfg_bad) begin
                     r_error <= 1'b1;
                  end else begin
                     r_plane    <= w_cfg_plane;
                     r_kk       <= w_cfg_kk;
                     r_nch      <= cfg_channels;
                     r_in_addr  <= input_addr;
                     r_wt_addr  <= weight_addr;
                     r_bn_addr  <= bn_param_addr;
                     r_out_addr <= output_addr;
                     r_chan     <= '0;
                     r_base     <= input_addr;
                     r_total    <= w_cfg_plane;
                     r_issued   <= '0;
                     r_state    <= S_LOAD_IN;
                  end
               end
               S_LOAD_IN: if (w_phase_end) begin
                  r_base   <= r_wt_addr + f_off(32'(r_chan), r_kk);
                  r_total  <= r_kk;
                  r_issued <= '0;
                  r_state  <= S_LOAD_W;
               end
               S_LOAD_W: if (w_phase_end) begin
                  r_base   <= r_bn_addr + f_off(32'(r_chan), 32'(BN_PARAMS));
                  r_total  <= 32'(BN_PARAMS);
                  r_issued <= '0;
                  r_state  <= S_LOAD_BN;
               end
               S_LOAD_BN: if (w_phase_end) begin
                  r_out_base <= r_out_addr + f_off(32'(r_chan), r_plane);
                  r_accepted <= '0;
                  r_written  <= '0;
                  r_state    <= S_WAIT_PROC;
               end
               S_WAIT_PROC: if (processing_done) r_state <= S_STORE;
               S_STORE: if (r_written == r_plane) begin
                  if (r_chan < r_nch - 16'd1) begin
                     r_chan   <= w_next_chan;
                     r_base   <= r_in_addr + f_off(32'(w_next_chan), r_plane);
                     r_total  <= r_plane;
                     r_issued <= '0;
                     r_state  <= S_LOAD_IN;
                  end else begin
                     r_done  <= 1'b1;
                     r_state <= S_IDLE;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_vdma_burst_engine.sv
// Directed bench for vdma_burst_engine: memory/datapath models plus read, write and act scoreboards.
module tb_vdma_burst_engine;
   logic        clk = 1'b0;
   logic        rst_n, start, abort;
   logic [15:0] cfg_img_w, cfg_img_h, cfg_channels;
   logic [3:0]  cfg_kernel;
   logic [31:0] input_addr, weight_addr, bn_param_addr, output_addr;
   logic        rd_req, rd_gnt, rd_valid, wr_req, wr_ack, act_valid, act_ready, processing_done;
   logic [31:0] rd_addr, wr_addr;
   logic [3:0]  rd_len;
   logic [15:0] rd_data, wr_data, act_data;
   logic [1:0]  load_phase;
   logic        busy, done, error;

   always #5 clk = ~clk;

   vdma_burst_engine #(.DATA_WIDTH(16), .ADDR_WIDTH(32), .BURST_LEN(8), .OUT_FIFO_DEPTH(4), .BN_PARAMS(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .cfg_img_w(cfg_img_w), .cfg_img_h(cfg_img_h), .cfg_kernel(cfg_kernel), .cfg_channels(cfg_channels),
      .input_addr(input_addr), .weight_addr(weight_addr), .bn_param_addr(bn_param_addr), .output_addr(output_addr),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_gnt(rd_gnt), .rd_data(rd_data), .rd_valid(rd_valid),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
      .act_data(act_data), .act_valid(act_valid), .act_ready(act_ready), .processing_done(processing_done),
      .load_phase(load_phase), .busy(busy), .done(done), .error(error));

   typedef struct packed { logic [31:0] addr; logic [3:0] len; logic [1:0] ph; } rd_t;
   typedef struct packed { logic [31:0] addr; logic [15:0] data; } wr_t;

   rd_t         exp_rd[$];
   wr_t         exp_wr[$];
   logic [15:0] act_q[$];
   int          total = 0, bad = 0;
   int          gnt_dly = 0, acc_cnt = 0;
   bit          ack_stall = 1'b0, abort_mode = 1'b0, stopped = 1'b0, late_go = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, expv);
      end
   endtask

   // Memory read port model: grants after gnt_dly cycles, then returns rd_len beats.
   initial begin
      rd_t e;
      int  nb;
      rd_gnt = 1'b0; rd_valid = 1'b0; rd_data = '0;
      forever begin
         @(negedge clk);
         rd_valid = 1'b0; rd_gnt = 1'b0;
         if (rd_req) begin
            check("rd_exp_avail", exp_rd.size() > 0, 1);
            if (exp_rd.size() > 0) begin
               e = exp_rd.pop_front();
               check("rd_addr", rd_addr, e.addr);
               check("rd_len", rd_len, e.len);
               for (int d = 0; d < gnt_dly; d++) begin
                  @(negedge clk);
                  check("rd_req_hold", rd_req, 1);
                  check("rd_addr_hold", rd_addr, e.addr);
                  check("rd_len_hold", rd_len, e.len);
               end
               rd_gnt = 1'b1;
               @(negedge clk);
               rd_gnt = 1'b0;
               check("rd_req_drop", rd_req, 0);
               nb = abort_mode ? 3 : int'(e.len);
               for (int b = 0; b < nb; b++) begin
                  if (b > 0) @(negedge clk);
                  rd_valid = 1'b1;
                  rd_data  = 16'(b + 1);
                  check("load_phase", load_phase, e.ph);
               end
               if (abort_mode) begin
                  @(negedge clk);
                  rd_valid = 1'b0;
                  stopped  = 1'b1;
                  wait (late_go);
                  for (int b = 0; b < 5; b++) begin
                     @(negedge clk);
                     rd_valid = 1'b1;
                  end
                  @(negedge clk);
                  rd_valid = 1'b0;
                  stopped  = 1'b0;
               end
            end
         end
      end
   end

   // Write port model: acks each held write unless stalled, checking against the scoreboard.
   initial begin
      wr_t w;
      wr_ack = 1'b0;
      forever begin
         @(negedge clk);
         wr_ack = 1'b0;
         if (wr_req && !ack_stall) begin
            check("wr_exp_avail", exp_wr.size() > 0, 1);
            if (exp_wr.size() > 0) begin
               w = exp_wr.pop_front();
               check("wr_addr", wr_addr, w.addr);
               check("wr_data", wr_data, w.data);
            end
            wr_ack = 1'b1;
         end
      end
   end

   // Activation source: holds act_valid while data is queued.
   initial begin
      act_valid = 1'b0; act_data = '0;
      forever begin
         @(negedge clk);
         if (act_q.size() > 0) begin
            act_valid = 1'b1;
            act_data  = act_q[0];
            #1;
            if (act_ready) begin
               void'(act_q.pop_front());
               acc_cnt++;
            end
         end else begin
            act_valid = 1'b0;
         end
      end
   end

   initial begin
      processing_done = 1'b0;
      forever begin
         @(negedge clk);
         processing_done = busy && (load_phase == 2'd3);
      end
   end

   task automatic push_bursts(input logic [31:0] base, input int n, input logic [1:0] ph);
      rd_t e;
      int  iss = 0;
      while (iss < n) begin
         e.addr = base + 32'(iss * 2);
         e.len  = 4'((n - iss > 8) ? 8 : n - iss);
         e.ph   = ph;
         exp_rd.push_back(e);
         iss += int'(e.len);
      end
   endtask

   task automatic run_job(input int w, h, k, ch, input logic [31:0] ia, wa, ba, oa,
                          input int dly, input bit stall, input int job);
      int          plane = w * h;
      int          kk    = k * k;
      wr_t         we;
      logic [15:0] d;
      bit          done_seen = 1'b0, stall_done = 1'b0;
      gnt_dly = dly; ack_stall = stall; acc_cnt = 0;
      for (int c = 0; c < ch; c++) begin
         push_bursts(ia + 32'(c * plane * 2), plane, 2'd0);
         push_bursts(wa + 32'(c * kk * 2), kk, 2'd1);
         push_bursts(ba + 32'(c * 8), 4, 2'd2);
         for (int i = 0; i < plane; i++) begin
            d = 16'(job * 4096 + c * 256 + i);
            we.addr = oa + 32'(c * plane * 2 + i * 2);
            we.data = d;
            exp_wr.push_back(we);
            act_q.push_back(d);
         end
      end
      @(negedge clk);
      cfg_img_w = 16'(w); cfg_img_h = 16'(h); cfg_kernel = 4'(k); cfg_channels = 16'(ch);
      input_addr = ia; weight_addr = wa; bn_param_addr = ba; output_addr = oa;
      start = 1'b1;
      for (int cyc = 0; cyc < 4000 && !done_seen; cyc++) begin
         @(negedge clk);
         if (cyc == 5) begin
            start = 1'b1; cfg_img_w = 16'd7; cfg_channels = 16'd3;
         end else begin
            start = 1'b0;
         end
         if (stall && !stall_done && busy && load_phase == 2'd3) begin
            repeat (10) @(negedge clk);
            check("fifo_pushes", acc_cnt, 4);
            check("fifo_full_ready", act_ready, 0);
            check("fifo_full_wr_req", wr_req, 1);
            ack_stall  = 1'b0;
            stall_done = 1'b1;
         end
         if (done) done_seen = 1'b1;
      end
      start = 1'b0;
      check("done_seen", done_seen, 1);
      @(negedge clk);
      check("done_pulse", done, 0);
      check("busy_after", busy, 0);
      check("rd_left", exp_rd.size(), 0);
      check("wr_left", exp_wr.size(), 0);
      check("act_left", act_q.size(), 0);
   endtask

   task automatic err_test(input int w, h, k, ch);
      @(negedge clk);
      cfg_img_w = 16'(w); cfg_img_h = 16'(h); cfg_kernel = 4'(k); cfg_channels = 16'(ch);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("err_pulse", error, 1);
      check("err_busy", busy, 0);
      @(negedge clk);
      check("err_pulse_end", error, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("err_no_rd_req", rd_req, 0);
         check("err_idle", busy, 0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rd_t e;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      cfg_img_w = '0; cfg_img_h = '0; cfg_kernel = '0; cfg_channels = '0;
      input_addr = '0; weight_addr = '0; bn_param_addr = '0; output_addr = '0;
      repeat (3) @(negedge clk);
      check("rst_rd_req", rd_req, 0);
      check("rst_wr_req", wr_req, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_load_phase", load_phase, 3);
      check("rst_rd_addr", rd_addr, 0);
      check("rst_rd_len", rd_len, 0);
      check("rst_act_ready", act_ready, 0);
      check("rst_wr_addr", wr_addr, 0);
      rst_n = 1'b1;
      @(negedge clk);

      run_job(4, 2, 3, 1, 32'h100, 32'h200, 32'h300, 32'h400, 0, 1'b0, 1);
      run_job(4, 4, 2, 2, 32'h1000, 32'h3000, 32'h4000, 32'h5000, 3, 1'b0, 2);
      run_job(4, 2, 1, 1, 32'h600, 32'h700, 32'h800, 32'h900, 0, 1'b1, 3);

      err_test(4, 2, 0, 1);
      err_test(0, 2, 3, 1);

      // Abort with a burst open, then feed stale beats into an idle engine.
      gnt_dly = 0;
      e.addr = 32'h2000; e.len = 4'd8; e.ph = 2'd0;
      exp_rd.push_back(e);
      abort_mode = 1'b1;
      @(negedge clk);
      cfg_img_w = 16'd4; cfg_img_h = 16'd4; cfg_kernel = 4'd1; cfg_channels = 16'd1;
      input_addr = 32'h2000;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 50 && !stopped; i++) @(negedge clk);
      check("abort_burst_open", stopped, 1);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_rd_req", rd_req, 0);
      check("abort_wr_req", wr_req, 0);
      late_go = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("late_busy", busy, 0);
         check("late_rd_req", rd_req, 0);
      end
      late_go = 1'b0;
      abort_mode = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_rd_left", exp_rd.size(), 0);

      run_job(4, 2, 3, 1, 32'h100, 32'h200, 32'h300, 32'h400, 0, 1'b0, 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
